// File: rtl/fifo_pop_stream_adapter_pkg.sv
// rtl/fifo_pop_stream_adapter_pkg.sv - shared constants, types and helpers for the pop-to-stream adapter
package fifo_adapter_pkg;

    localparam int STAT_WIDTH = 32;

    typedef logic [STAT_WIDTH-1:0] stat_cnt_t;

    // Counter increment that holds at all-ones instead of wrapping to zero
    function automatic stat_cnt_t sat_inc(input stat_cnt_t value);
        return (value == {STAT_WIDTH{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_pop_stream_adapter_if.sv
// rtl/fifo_pop_stream_adapter_if.sv - FIFO pop port and output stream handshake bundle
interface fifo_pop_stream_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_pop_enable;
    logic                  fifo_pop_valid;
    logic [DATA_WIDTH-1:0] fifo_pop_data;
    logic                  fifo_pop_empty;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    // Adapter side: pops the FIFO and sources the stream
    modport master (
        output fifo_pop_enable,
        input  fifo_pop_valid,
        input  fifo_pop_data,
        input  fifo_pop_empty,
        output out_valid,
        output out_data,
        input  out_ready
    );

    // Environment side: the FIFO read port plus the stream consumer
    modport slave (
        input  fifo_pop_enable,
        output fifo_pop_valid,
        output fifo_pop_data,
        output fifo_pop_empty,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/fifo_pop_stream_adapter_skid_ring_buffer.sv
// rtl/fifo_pop_stream_adapter_skid_ring_buffer.sv - power-of-two ring buffer with wrap-bit pointers
module skid_ring_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [LOG_DEPTH:0]    occupancy
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    // The extra pointer bit separates full (difference DEPTH) from empty (difference 0)
    logic [LOG_DEPTH:0]    wr_ptr;
    logic [LOG_DEPTH:0]    rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign occupancy = wr_ptr - rd_ptr;
    assign rd_data   = mem[rd_ptr[LOG_DEPTH-1:0]];

    // Storage and pointer update; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[LOG_DEPTH-1:0]] <= wr_data;
                wr_ptr                     <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_pop_stream_adapter.sv
// rtl/fifo_pop_stream_adapter.sv - credit-managed pop-to-stream adapter; FIFO_POP_ADAPTER_STATS_EN adds beat/stall counters
module fifo_pop_stream_adapter
    import fifo_adapter_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int LOG_SKID_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        clear_n,
    fifo_pop_stream_adapter_if.master   bus,
    output logic [LOG_SKID_DEPTH:0]     occupancy,
`ifdef FIFO_POP_ADAPTER_STATS_EN
    output stat_cnt_t                   stat_words,
    output stat_cnt_t                   stat_stall,
`endif
    output logic                        error
);
    localparam int SKID_DEPTH = 1 << LOG_SKID_DEPTH;
    localparam logic [LOG_SKID_DEPTH+1:0] CREDIT_LIMIT = (LOG_SKID_DEPTH + 2)'(SKID_DEPTH);
    localparam logic [LOG_SKID_DEPTH:0]   FULL_LEVEL   = (LOG_SKID_DEPTH + 1)'(SKID_DEPTH);

    logic                  inflight;
    logic                  full;
    logic                  rd_en;
    logic                  wr_en;
    logic                  credit_ok;
    logic [DATA_WIDTH-1:0] rd_data;

    // A pop is only issued when a slot is guaranteed for its data, counting the word still in flight
    assign credit_ok           = ({1'b0, occupancy} + {{(LOG_SKID_DEPTH + 1){1'b0}}, inflight}) < CREDIT_LIMIT;
    assign bus.fifo_pop_enable = clear_n & ~bus.fifo_pop_empty & credit_ok;

    assign full          = (occupancy == FULL_LEVEL);
    assign bus.out_valid = (occupancy != '0);
    assign bus.out_data  = rd_data;
    assign rd_en         = bus.out_valid & bus.out_ready;
    // A full buffer still accepts a word when the head leaves in the same cycle
    assign wr_en         = clear_n & bus.fifo_pop_valid & (~full | rd_en);

    skid_ring_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG_DEPTH  (LOG_SKID_DEPTH)
    ) u_ring (
        .clk       (clk),
        .resetn    (clear_n),
        .wr_en     (wr_en),
        .wr_data   (bus.fifo_pop_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .occupancy (occupancy)
    );

    // Remember whether a pop was issued last cycle; its data arrives this cycle
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_pop_enable;
        end
    end

    // Sticky flag for a valid nobody asked for, or a valid with nowhere to go
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            error <= 1'b0;
        end else if (bus.fifo_pop_valid & (~inflight | (full & ~rd_en))) begin
            error <= 1'b1;
        end
    end

`ifdef FIFO_POP_ADAPTER_STATS_EN
    // Saturating counts of delivered beats and back-pressured cycles
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            if (rd_en) begin
                stat_words <= sat_inc(stat_words);
            end
            if (bus.out_valid & ~bus.out_ready) begin
                stat_stall <= sat_inc(stat_stall);
            end
        end
    end
`endif
endmodule
